// File: rtl/register_bank_arbiter.sv
// Round-robin sequencer sharing a tri-stated register bank between
// the CPU core (M0) and the debug/loader port (M1).
module register_bank_arbiter #(
  parameter int NrOfRegs = 8,
  parameter int NrOfBits = 8,
  parameter int AddrBits = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic                m0_we,
  input  logic                m1_we,
  input  logic [AddrBits-1:0] m0_addr,
  input  logic [AddrBits-1:0] m1_addr,
  input  logic [NrOfBits-1:0] m0_wdata,
  input  logic [NrOfBits-1:0] m1_wdata,
  output logic                m0_ready,
  output logic                m1_ready,
  output logic                m0_rsp,
  output logic                m1_rsp,
  output logic                rsp_err,
  output logic [NrOfBits-1:0] rsp_rdata,
  output logic [NrOfRegs-1:0] reg_load,
  output logic [NrOfRegs-1:0] reg_cs,
  output logic [NrOfBits-1:0] bus_wdata,
  input  logic [NrOfBits-1:0] bus_rdata
);

  localparam logic [AddrBits:0] NREGS = NrOfRegs[AddrBits:0];

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic                owner;
    logic                we;
    logic                err;
    logic [AddrBits-1:0] addr;
    logic [NrOfBits-1:0] wdata;
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  // rr_q = 1 means M1 won the last grant
  logic rr_q, rr_d;

  logic [NrOfRegs-1:0] load_q, load_d;
  logic [NrOfRegs-1:0] cs_q, cs_d;
  logic [NrOfBits-1:0] wd_q, wd_d;
  logic [NrOfBits-1:0] rd_q, rd_d;
  logic rsp0_q, rsp0_d;
  logic rsp1_q, rsp1_d;
  logic err_q, err_d;

  logic                gnt_ok;
  logic                gnt0;
  logic                gnt1;
  logic                nx_we;
  logic [AddrBits-1:0] nx_addr;
  logic [NrOfBits-1:0] nx_wdata;
  logic                nx_inr;
  logic [NrOfRegs-1:0] nx_sel;

  assign gnt_ok = (state_q == IDLE) & Tick & Reset;
  assign gnt0   = gnt_ok & m0_req & (~m1_req | rr_q);
  assign gnt1   = gnt_ok & m1_req & (~m0_req | ~rr_q);

  assign nx_we    = gnt1 ? m1_we    : m0_we;
  assign nx_addr  = gnt1 ? m1_addr  : m0_addr;
  assign nx_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign nx_inr   = {1'b0, nx_addr} < NREGS;
  assign nx_sel   = NrOfRegs'(1) << nx_addr;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rr_d    = rr_q;
    load_d  = load_q;
    cs_d    = cs_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    rsp0_d  = rsp0_q;
    rsp1_d  = rsp1_q;
    err_d   = err_q;
    if (Tick) begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            op_d.owner = gnt1;
            op_d.we    = nx_we;
            op_d.err   = ~nx_inr;
            op_d.addr  = nx_addr;
            op_d.wdata = nx_wdata;
            rr_d       = gnt1;
            state_d    = EXEC;
            if (nx_inr && nx_we) begin
              load_d = nx_sel;
              wd_d   = nx_wdata;
            end else if (nx_inr) begin
              cs_d = ~nx_sel;
            end
          end
        end
        EXEC: begin
          load_d  = '0;
          cs_d    = '1;
          wd_d    = '0;
          rsp0_d  = ~op_q.owner;
          rsp1_d  = op_q.owner;
          err_d   = op_q.err;
          rd_d    = (!op_q.we && !op_q.err) ? bus_rdata : '0;
          state_d = RESP;
        end
        RESP: begin
          rsp0_d  = 1'b0;
          rsp1_d  = 1'b0;
          err_d   = 1'b0;
          rd_d    = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rr_q    <= 1'b1;
      load_q  <= '0;
      cs_q    <= '1;
      wd_q    <= '0;
      rd_q    <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rr_q    <= rr_d;
      load_q  <= load_d;
      cs_q    <= cs_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
      err_q   <= err_d;
    end
  end

  // Strobes are qualified by Tick so a stalled cycle never loads or responds
  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign m0_rsp    = rsp0_q & Tick;
  assign m1_rsp    = rsp1_q & Tick;
  assign rsp_err   = err_q;
  assign rsp_rdata = rd_q;
  assign reg_load  = load_q & {NrOfRegs{Tick}};
  assign reg_cs    = cs_q;
  assign bus_wdata = wd_q;

endmodule
